// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM-backed stream FIFO: default widths, pointer
// width derivation and output-buffer sizing.
package sram_fifo_pkg;

  localparam int DATA_WIDTH_D = 32;
  localparam int ADDR_WIDTH_D = 8;
  localparam int NUM_WMASKS_D = 4;

  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_IW    = $clog2(OBUF_DEPTH);
  localparam int OBUF_CW    = $clog2(OBUF_DEPTH + 1);

  // Extra MSB is the wrap bit, so full and empty are distinguishable.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry output buffer that absorbs the macro read latency and presents
// a held-stable head word to the consumer.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [OBUF_CW-1:0]    count
);

  logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
  logic [OBUF_IW-1:0]    wr_idx;
  logic [OBUF_IW-1:0]    rd_idx;

  assign dout = mem[rd_idx];

  // Issue logic upstream guarantees push never lands on a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= din;
        wr_idx      <= wr_idx + 1'b1;
      end
      if (pop) rd_idx <= rd_idx + 1'b1;
      count <= count + OBUF_CW'(push) - OBUF_CW'(pop);
    end
  end

endmodule

// File: rtl/sram_stream_fifo.sv
// Stream FIFO using an external 1rw1r SRAM macro as storage (port 0 write,
// port 1 read). Optional occupancy/high-water ports under FIFO_LEVEL_EN.
module sram_stream_fifo
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int NUM_WMASKS = NUM_WMASKS_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   hwm,
  input  logic                  hwm_clr
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int OW = OBUF_CW + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]      wr_ptr, rd_ptr, sram_count;
  logic               inflight;
  logic [OBUF_CW-1:0] obuf_count;
  logic [OW-1:0]      obuf_occ;
  logic               push_fire, pop_fire, issue;

  assign sram_count = wr_ptr - rd_ptr;
  assign in_ready   = (sram_count != DEPTH);
  assign push_fire  = in_valid & in_ready;
  assign out_valid  = (obuf_count != '0);
  assign pop_fire   = out_valid & out_ready;

  // obuf_count + inflight - pop_fire < OBUF_DEPTH, with pop moved right to
  // keep the arithmetic unsigned.
  assign obuf_occ = OW'(obuf_count) + OW'(inflight);
  assign issue    = (sram_count != '0) && (obuf_occ < OW'(OBUF_DEPTH) + OW'(pop_fire));

  assign sram_csb0   = ~push_fire;
  assign sram_web0   = 1'b0;
  assign sram_wmask0 = '1;
  assign sram_addr0  = wr_ptr[ADDR_WIDTH-1:0];
  assign sram_din0   = in_data;
  assign sram_csb1   = ~issue;
  assign sram_addr1  = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(push_fire);
      rd_ptr   <= rd_ptr + PW'(issue);
      inflight <= issue;
    end
  end

  sram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight),
    .din  (sram_dout1),
    .pop  (pop_fire),
    .dout (out_data),
    .count(obuf_count)
  );

`ifdef FIFO_LEVEL_EN
  assign level = sram_count + PW'(inflight) + PW'(obuf_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             hwm <= '0;
    else if (hwm_clr)       hwm <= '0;
    else if (level > hwm)   hwm <= level;
  end
`endif

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Bench for sram_stream_fifo with a behavioural 1rw1r macro and a queue
// scoreboard; level/hwm checks are active when FIFO_LEVEL_EN is defined.
module tb_sram_stream_fifo;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CAP   = DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout1;
`ifdef FIFO_LEVEL_EN
  logic [AW:0]   level, hwm;
  logic          hwm_clr = 1'b0;
  int            peak = 0;
`endif

  always #5 clk = ~clk;

  sram_stream_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
`ifdef FIFO_LEVEL_EN
    , .level(level), .hwm(hwm), .hwm_clr(hwm_clr)
`endif
  );

  // Behavioural macro: port 0 write, port 1 registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  int coll_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && !sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1) begin
      coll_cnt++;
      $display("FAIL collision: same address %h on both ports at %0t", sram_addr0, $time);
    end
  end

  int            checks = 0, errors = 0, popped = 0;
  logic [DW-1:0] model [$];
  logic          prev_stall = 1'b0, ov;
  logic [DW-1:0] prev_data = '0;

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model.delete();
    prev_stall = 1'b0;
`ifdef FIFO_LEVEL_EN
    peak = 0;
`endif
  endtask

  // One cycle: drive, sample mid-cycle, score handshakes against the queue model.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, output logic acc);
    logic [DW-1:0] exp;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    ov = out_valid;
    if (prev_stall) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%h, need valid=1 data=%h", out_valid, out_data, prev_data);
      end
    end
`ifdef FIFO_LEVEL_EN
    checks++;
    if (level !== (AW+1)'(model.size())) begin
      errors++;
      $display("FAIL level: got %0d, need %0d", level, model.size());
    end
    checks++;
    if (hwm !== (AW+1)'(peak)) begin
      errors++;
      $display("FAIL hwm: got %0d, need %0d", hwm, peak);
    end
    if (hwm_clr) peak = 0;
    else if (model.size() > peak) peak = model.size();
`endif
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      checks++;
      popped++;
      if (model.size() == 0) begin
        errors++;
        $display("FAIL spurious_pop: got data %h, need no valid word", out_data);
      end else begin
        exp = model.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL pop_data: got %h, need %h", out_data, exp);
        end
      end
    end
    if (acc) model.push_back(id);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic test_reset();
    logic acc;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(i + 100), 1'b0, acc);
    @(negedge clk);
    #2;
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: got out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
    end
    checks++;
    if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_csb: got csb0=%b csb1=%b, need 1/1", sram_csb0, sram_csb1);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, need 0", out_data);
    end
    checks++;
    if (sram_web0 !== 1'b0 || sram_wmask0 !== 4'hF) begin
      errors++;
      $display("FAIL tie_offs: got web0=%b wmask0=%h, need 0/f", sram_web0, sram_wmask0);
    end
`ifdef FIFO_LEVEL_EN
    checks++;
    if (level !== '0 || hwm !== '0) begin
      errors++;
      $display("FAIL reset_level: got level=%0d hwm=%0d, need 0/0", level, hwm);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model.delete();
    prev_stall = 1'b0;
`ifdef FIFO_LEVEL_EN
    peak = 0;
`endif
  endtask

  task automatic test_single_word();
    logic acc;
    int   n = -1;
    step(1'b1, 32'hDEADBEEF, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got %b, need 1", acc);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, 1'b1, acc);
      if (ov && n < 0) n = i;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, need 3", n);
    end
    checks++;
    if (ov !== 1'b0 || model.size() != 0) begin
      errors++;
      $display("FAIL single_empty: got out_valid=%b queued=%0d, need 0/0", ov, model.size());
    end
  endtask

  task automatic test_fill_drain();
    logic acc;
    int   nxt = 0, p0;
    for (int i = 0; i < 301; i++) begin
      step(1'b1, DW'(nxt), 1'b0, acc);
      if (acc) nxt++;
    end
    checks++;
    if (nxt != CAP) begin
      errors++;
      $display("FAIL fill_count: got %0d accepted, need %0d", nxt, CAP);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready: got in_ready=%b, need 0", in_ready);
    end
`ifdef FIFO_LEVEL_EN
    checks++;
    if (level !== (AW+1)'(CAP)) begin
      errors++;
      $display("FAIL fill_level: got %0d, need %0d", level, CAP);
    end
`endif
    p0 = popped;
    for (int i = 0; i < 270; i++) step(1'b0, '0, 1'b1, acc);
    checks++;
    if (popped - p0 != CAP || model.size() != 0) begin
      errors++;
      $display("FAIL drain_count: got %0d popped %0d left, need %0d/0", popped - p0, model.size(), CAP);
    end
  endtask

  task automatic test_streaming_wrap();
    logic acc;
    int   refused = 0, first = -1, last = -1, nvalid = 0, p0 = popped;
    for (int c = 0; c < 1012; c++) begin
      if (c < 1000) step(1'b1, DW'(c) ^ 32'hA5A50000, 1'b1, acc);
      else          step(1'b0, '0, 1'b1, acc);
      if (c < 1000 && !acc) refused++;
      if (ov) begin
        if (first < 0) first = c;
        last = c;
        nvalid++;
      end
    end
    checks++;
    if (refused != 0) begin
      errors++;
      $display("FAIL stream_ready: got %0d refused pushes, need 0", refused);
    end
    checks++;
    if (popped - p0 != 1000) begin
      errors++;
      $display("FAIL stream_count: got %0d popped, need 1000", popped - p0);
    end
    checks++;
    if (first != 3 || last - first + 1 != 1000 || nvalid != 1000) begin
      errors++;
      $display("FAIL stream_rate: got first=%0d span=%0d valid=%0d, need 3/1000/1000",
               first, last - first + 1, nvalid);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    for (int c = 0; c < 5000; c++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), acc);
    for (int c = 0; c < 300; c++) step(1'b0, '0, 1'b1, acc);
    checks++;
    if (model.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d words left, need 0", model.size());
    end
  endtask

`ifdef FIFO_LEVEL_EN
  task automatic test_hwm_clr();
    logic acc;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, acc);
    hwm_clr = 1'b1;
    step(1'b0, '0, 1'b0, acc);
    hwm_clr = 1'b0;
    step(1'b0, '0, 1'b0, acc);
    checks++;
    if (hwm !== (AW+1)'(5)) begin
      errors++;
      $display("FAIL hwm_reload: got %0d, need 5", hwm);
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, acc);
  endtask
`endif

  task automatic test_reset_midstream();
    logic acc;
    int   first = -1;
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, acc);
    step(1'b0, '0, 1'b1, acc);
    do_reset();
    step(1'b1, 32'h1, 1'b0, acc);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b0, acc);
      if (ov && first < 0) begin
        first = i;
        checks++;
        if (out_data !== 32'h1) begin
          errors++;
          $display("FAIL midreset_data: got %h, need 00000001", out_data);
        end
      end
    end
    checks++;
    if (first < 0) begin
      errors++;
      $display("FAIL midreset_valid: got no out_valid in 8 cycles, need one");
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, acc);
    checks++;
    if (model.size() != 0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL midreset_empty: got %0d queued valid=%b, need 0/0", model.size(), ov);
    end
  endtask

  task automatic test_no_collision();
    checks++;
    if (coll_cnt != 0) begin
      errors++;
      $display("FAIL collision_total: got %0d, need 0", coll_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_drain();
    test_streaming_wrap();
    test_backpressure();
`ifdef FIFO_LEVEL_EN
    test_hwm_clr();
`endif
    test_reset_midstream();
    test_no_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
